// File: rtl/avr_mul_seq.sv
// avr_mul_seq: sequencer for MUL-family instructions.
// It latches the operands and the mode bits, then drives the avr_mul
// pipeline through one CALC cycle. In the WB cycle it forwards the
// product and the C/Z flags to R1:R0 and to SREG.
module avr_mul_seq (
  input  logic        cp2,
  input  logic        ireset,
  input  logic        cp2en,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  rd_data,
  input  logic [7:0]  rr_data,
  input  logic [15:0] mr_in,
  input  logic        mc_in,
  input  logic        mz_in,
  output logic        mul_fmul,
  output logic        mul_muls,
  output logic        mul_mulsu,
  output logic [7:0]  mul_rd,
  output logic [7:0]  mul_rr,
  output logic        mul_en,
  output logic        busy,
  output logic        wb_en,
  output logic [15:0] wb_data,
  output logic        flag_we,
  output logic        sreg_c,
  output logic        sreg_z,
  output logic        illegal_op
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WB} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rd_q, rd_d;
  logic [7:0]  rr_q, rr_d;
  logic        fmul_q, fmul_d;
  logic        muls_q, muls_d;
  logic        mulsu_q, mulsu_d;
  logic        illegal_q, illegal_d;

  logic        can_accept;
  logic        op_legal;
  logic        accept;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_WB);
  assign op_legal   = (op[2:1] != 2'b11);
  assign accept     = start && op_legal && can_accept;

  // Next-state, operand/mode latch and combinational strobes.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    rr_d      = rr_q;
    fmul_d    = fmul_q;
    muls_d    = muls_q;
    mulsu_d   = mulsu_q;
    illegal_d = start && !op_legal && can_accept;
    busy      = 1'b0;
    mul_en    = 1'b0;
    wb_en     = 1'b0;
    flag_we   = 1'b0;
    wb_data   = '0;
    sreg_c    = 1'b0;
    sreg_z    = 1'b0;

    unique case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: begin
        busy    = 1'b1;
        mul_en  = cp2en;
        state_d = S_WB;
      end
      S_WB: begin
        wb_en   = 1'b1;
        flag_we = 1'b1;
        wb_data = mr_in;
        sreg_c  = mc_in;
        sreg_z  = mz_in;
        state_d = accept ? S_CALC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      rd_d    = rd_data;
      rr_d    = rr_data;
      fmul_d  = (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
      muls_d  = (op == 3'b001) || (op == 3'b100);
      mulsu_d = (op == 3'b010) || (op == 3'b101);
    end
  end

  // State and latched registers; cp2en low freezes everything.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      rr_q      <= '0;
      fmul_q    <= 1'b0;
      muls_q    <= 1'b0;
      mulsu_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (cp2en) begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      rr_q      <= rr_d;
      fmul_q    <= fmul_d;
      muls_q    <= muls_d;
      mulsu_q   <= mulsu_d;
      illegal_q <= illegal_d;
    end
  end

  assign mul_rd     = rd_q;
  assign mul_rr     = rr_q;
  assign mul_fmul   = fmul_q;
  assign mul_muls   = muls_q;
  assign mul_mulsu  = mulsu_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_avr_mul_seq.sv
// Testbench for avr_mul_seq. It includes a behavioural avr_mul stand-in
// that captures the product on enabled mul_en edges. Results are checked
// through a writeback scoreboard.
module tb_avr_mul_seq;

  logic        cp2 = 1'b0;
  logic        ireset, cp2en, start;
  logic [2:0]  op;
  logic [7:0]  rd_data, rr_data;
  logic [15:0] mr_in;
  logic        mc_in, mz_in;
  logic        mul_fmul, mul_muls, mul_mulsu;
  logic [7:0]  mul_rd, mul_rr;
  logic        mul_en, busy, wb_en, flag_we, sreg_c, sreg_z, illegal_op;
  logic [15:0] wb_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 cp2 = ~cp2;

  avr_mul_seq dut (
    .cp2(cp2), .ireset(ireset), .cp2en(cp2en), .start(start), .op(op),
    .rd_data(rd_data), .rr_data(rr_data), .mr_in(mr_in), .mc_in(mc_in),
    .mz_in(mz_in), .mul_fmul(mul_fmul), .mul_muls(mul_muls),
    .mul_mulsu(mul_mulsu), .mul_rd(mul_rd), .mul_rr(mul_rr),
    .mul_en(mul_en), .busy(busy), .wb_en(wb_en), .wb_data(wb_data),
    .flag_we(flag_we), .sreg_c(sreg_c), .sreg_z(sreg_z),
    .illegal_op(illegal_op)
  );

  // Behavioural multiplier: returns {C, result}.
  function automatic logic [16:0] mul_model(input logic [7:0] a8, input logic [7:0] b8,
                                            input logic f, input logic s, input logic su);
    logic signed [17:0] a, b, p;
    logic [15:0] raw;
    a   = (s || su) ? {{10{a8[7]}}, a8} : {10'd0, a8};
    b   = s ? {{10{b8[7]}}, b8} : {10'd0, b8};
    p   = a * b;
    raw = p[15:0];
    return {raw[15], f ? {raw[14:0], 1'b0} : raw};
  endfunction

  logic [15:0] m_r = '0;
  logic        m_c = 1'b0;
  always @(posedge cp2) if (mul_en) {m_c, m_r} <= mul_model(mul_rd, mul_rr, mul_fmul, mul_muls, mul_mulsu);
  assign mr_in = m_r;
  assign mc_in = m_c;
  assign mz_in = (m_r == 16'h0000);

  typedef struct { logic [15:0] data; logic c; logic z; } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Writeback monitor: each enabled WB cycle must match the oldest expectation.
  always @(negedge cp2) begin
    if (ireset && wb_en && cp2en) begin
      if (sb.size() == 0) chk("unexpected_wb", {31'd0, wb_en}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", {16'd0, wb_data}, {16'd0, e.data});
        chk("sreg_c", {31'd0, sreg_c}, {31'd0, e.c});
        chk("sreg_z", {31'd0, sreg_z}, {31'd0, e.z});
        chk("flag_we", {31'd0, flag_we}, 32'd1);
      end
    end
  end

  task automatic cyc();
    @(posedge cp2); #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    start = s; op = o; rd_data = a; rr_data = b;
  endtask

  task automatic push(input logic [15:0] d, input logic c, input logic z);
    exp_t e;
    e.data = d; e.c = c; e.z = z;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin cyc(); n++; end
    chk("drain_timeout", sb.size(), 0);
  endtask

  typedef struct {
    logic [2:0] op; logic [7:0] rd; logic [7:0] rr;
    logic [15:0] data; logic c; logic z;
    logic f; logic s; logic su;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{3'b000, 8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{3'b001, 8'hFF, 8'h02, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{3'b011, 8'h80, 8'h80, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{3'b000, 8'h00, 8'h55, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{3'b010, 8'hFF, 8'hFF, 16'hFF01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{3'b100, 8'h40, 8'h40, 16'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[6] = '{3'b000, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{3'b101, 8'hC0, 8'h40, 16'hE000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    ireset = 1'b0; cp2en = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_strobes", {27'd0, mul_en, wb_en, flag_we, illegal_op, sreg_c}, 0);
    chk("rst_operands", {16'd0, mul_rd, mul_rr}, 0);
    chk("rst_modes_wb", {13'd0, mul_fmul, mul_muls, mul_mulsu, wb_data}, 0);
    #1 ireset = 1'b1;
    cyc();

    // Table-driven single instructions.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vt[i].op, vt[i].rd, vt[i].rr);
      push(vt[i].data, vt[i].c, vt[i].z);
      cyc();                                   // now CALC
      drive(1'b0, 3'b000, 8'h00, 8'h00);
      @(negedge cp2);
      chk("calc_busy", {31'd0, busy}, 1);
      chk("calc_mul_en", {31'd0, mul_en}, 1);
      chk("calc_operands", {16'd0, mul_rd, mul_rr}, {16'd0, vt[i].rd, vt[i].rr});
      chk("calc_modes", {29'd0, mul_fmul, mul_muls, mul_mulsu}, {29'd0, vt[i].f, vt[i].s, vt[i].su});
      cyc();                                   // now WB
      @(negedge cp2);
      chk("wb_busy", {31'd0, busy}, 0);
      chk("wb_operands", {16'd0, mul_rd, mul_rr}, {16'd0, vt[i].rd, vt[i].rr});
      cyc();                                   // back in IDLE
      chk("idle_wb_en", {31'd0, wb_en}, 0);
      drain();
    end

    // Illegal op from IDLE.
    drive(1'b1, 3'b110, 8'h11, 8'h22);
    cyc();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("illegal_pulse", {31'd0, illegal_op}, 1);
    chk("illegal_busy", {31'd0, busy}, 0);
    chk("illegal_no_latch", {16'd0, mul_rd, mul_rr}, {16'd0, 8'hC0, 8'h40});
    cyc();
    chk("illegal_pulse_end", {31'd0, illegal_op}, 0);
    chk("illegal_idle", {30'd0, busy, wb_en}, 0);

    // Back-to-back: MUL 3x5, then FMULSU 0xC0x0x40 issued during WB.
    drive(1'b1, 3'b000, 8'h03, 8'h05);
    push(16'h000F, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    cyc();                                     // WB of first
    chk("b2b_wb1", {31'd0, wb_en}, 1);
    drive(1'b1, 3'b101, 8'hC0, 8'h40);
    push(16'hE000, 1'b1, 1'b0);
    cyc();                                     // CALC of second, no bubble
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("b2b_no_bubble", {31'd0, busy}, 1);
    chk("b2b_operands", {16'd0, mul_rd, mul_rr}, {16'd0, 8'hC0, 8'h40});
    cyc();
    chk("b2b_wb2", {31'd0, wb_en}, 1);
    drain();
    cyc();

    // Start during CALC is ignored, including an illegal op.
    drive(1'b1, 3'b000, 8'h02, 8'h02);
    push(16'h0004, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 3'b111, 8'h09, 8'h09);
    cyc();                                     // WB
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("calc_start_no_illegal", {31'd0, illegal_op}, 0);
    chk("calc_start_no_latch", {16'd0, mul_rd, mul_rr}, {16'd0, 8'h02, 8'h02});
    drain();
    cyc();
    chk("calc_start_idle", {31'd0, busy}, 0);

    // cp2en stall for three cycles while in CALC.
    drive(1'b1, 3'b000, 8'h0C, 8'h0A);
    push(16'h0078, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    cp2en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge cp2);
      chk("stall_busy", {31'd0, busy}, 1);
      chk("stall_mul_en", {31'd0, mul_en}, 0);
      chk("stall_operands", {16'd0, mul_rd, mul_rr}, {16'd0, 8'h0C, 8'h0A});
      cyc();
    end
    cp2en = 1'b1;
    @(negedge cp2);
    chk("stall_release_mul_en", {31'd0, mul_en}, 1);
    cyc();
    chk("stall_wb", {31'd0, wb_en}, 1);
    drain();
    cyc();

    // Asynchronous reset in the middle of CALC drops the instruction.
    drive(1'b1, 3'b000, 8'h0F, 8'h0F);
    cyc();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    #2 ireset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_strobes", {29'd0, mul_en, wb_en, illegal_op}, 0);
    chk("arst_operands", {16'd0, mul_rd, mul_rr}, 0);
    cyc();
    ireset = 1'b1;
    repeat (3) begin
      @(negedge cp2);
      chk("arst_no_wb", {31'd0, wb_en}, 0);
      cyc();
    end
    drive(1'b1, 3'b000, 8'h07, 8'h09);
    push(16'h003F, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    drain();
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
